// File: rtl/spi_arbiter.sv
// -----------------------------------------------------------------------------
// spi_arbiter
//   Round-robin arbiter that lets NUM_REQ requesters share one SPI master.
//   A granted request is turned into a single read or write event towards the
//   SPI master. Completion is tracked through the master's chip select and,
//   for reads, its read-data-valid pulse.
//
//   Optional feature: define SPI_ARB_TIMEOUT_EN to build a per-phase watchdog
//   that aborts a stuck transaction after TIMEOUT_CYCLES (o_err + o_done).
//   Without the macro no counter exists, o_err is 0 and the FSM waits forever.
//
// Ports
//   user_clk, user_rst : clock, asynchronous active-high reset
//   i_req / i_req_rd   : per-requester request level and type (1 = read)
//   i_req_wdata        : per-requester write payload, DATA_WIDTH per slot
//   o_ack / o_done     : per-requester one-cycle accept / complete pulses
//   o_rd_data          : read result, valid with o_done of a read
//   o_err              : one-cycle timeout abort pulse
//   o_busy             : FSM not idle
//   o_spi_rd_evt/o_spi_wr_evt/o_spi_wr_data : command to the SPI master
//   i_spi_rd_evt/i_spi_rd_data              : read return from the SPI master
//   i_mcs              : chip select driven by the SPI master
// -----------------------------------------------------------------------------
module spi_arbiter #(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned DATA_WIDTH      = 16,
  parameter logic        MCS_VALID_LEVEL = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES  = 4096
) (
  input  logic                          user_clk,
  input  logic                          user_rst,
  input  logic [NUM_REQ-1:0]            i_req,
  input  logic [NUM_REQ-1:0]            i_req_rd,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_wdata,
  output logic [NUM_REQ-1:0]            o_ack,
  output logic [NUM_REQ-1:0]            o_done,
  output logic [DATA_WIDTH-1:0]         o_rd_data,
  output logic                          o_err,
  output logic                          o_busy,
  output logic                          o_spi_rd_evt,
  output logic                          o_spi_wr_evt,
  output logic [DATA_WIDTH-1:0]         o_spi_wr_data,
  input  logic                          i_spi_rd_evt,
  input  logic [DATA_WIDTH-1:0]         i_spi_rd_data,
  input  logic                          i_mcs
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] OneHot0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("spi_arbiter: unsupported parameter value");
  end

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitStart,
    StWaitEnd,
    StDone
  } state_e;

  state_e                 state_q, state_d;
  logic [IdxW-1:0]        last_q, last_d;
  logic [IdxW-1:0]        win_q, win_d;
  logic                   is_rd_q, is_rd_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic                   rd_seen_q, rd_seen_d;
  logic [NUM_REQ-1:0]     ack_q, ack_d;
  logic [NUM_REQ-1:0]     done_q, done_d;
  logic                   rd_evt_q, rd_evt_d;
  logic                   wr_evt_q, wr_evt_d;
  logic [DATA_WIDTH-1:0]  rd_data_q, rd_data_d;

  logic [DATA_WIDTH-1:0]  wdata_arr [NUM_REQ];
  logic                   found;
  logic [IdxW-1:0]        pick;
  logic                   mcs_act;
  logic                   waiting;
  logic                   rd_capture;
  logic                   timeout;
  logic [NUM_REQ-1:0]     win_oh;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_slice
    assign wdata_arr[k] = i_req_wdata[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin pick: first requester at or after last_grant+1 (mod NUM_REQ).
  always_comb begin
    int unsigned idx;
    logic [IdxW-1:0] sel;
    found = 1'b0;
    pick  = last_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(last_q) + 32'd1 + i) % NUM_REQ;
      sel = IdxW'(idx);
      if (!found && i_req[sel]) begin
        found = 1'b1;
        pick  = sel;
      end
    end
  end

  assign mcs_act    = (i_mcs == MCS_VALID_LEVEL);
  assign waiting    = (state_q == StWaitStart) || (state_q == StWaitEnd);
  assign rd_capture = waiting && is_rd_q && i_spi_rd_evt;
  assign win_oh     = OneHot0 << win_q;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  assign timeout = waiting && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  // Restart on every state change so each phase gets its own budget.
  always_comb begin
    cnt_d = '0;
    if (waiting && (state_d == state_q)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign o_err = err_q;
`else
  assign timeout = 1'b0;
  assign o_err   = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    win_d     = win_q;
    is_rd_d   = is_rd_q;
    wdata_d   = wdata_q;
    rd_seen_d = rd_seen_q;
    ack_d     = '0;
    done_d    = '0;
    rd_evt_d  = 1'b0;
    wr_evt_d  = 1'b0;
    rd_data_d = rd_data_q;
`ifdef SPI_ARB_TIMEOUT_EN
    err_d     = 1'b0;
`endif

    case (state_q)
      StIdle: begin
        // o_done is shown during the first idle cycle; hold off one cycle so
        // a completion and the next accept never sit back to back.
        if (found && (done_q == '0)) begin
          win_d   = pick;
          is_rd_d = i_req_rd[pick];
          wdata_d = wdata_arr[pick];
          ack_d   = OneHot0 << pick;
          state_d = StIssue;
        end
      end
      StIssue: begin
        rd_seen_d = 1'b0;
        rd_evt_d  = is_rd_q;
        wr_evt_d  = !is_rd_q;
        state_d   = StWaitStart;
      end
      StWaitStart: begin
        if (mcs_act) begin
          state_d = StWaitEnd;
        end
      end
      StWaitEnd: begin
        // Read data may arrive before or after chip select releases.
        if (!mcs_act && (!is_rd_q || rd_seen_q || rd_capture)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        done_d  = win_oh;
        last_d  = win_q;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (rd_capture) begin
      rd_data_d = i_spi_rd_data;
      rd_seen_d = 1'b1;
    end

`ifdef SPI_ARB_TIMEOUT_EN
    if (timeout) begin
      state_d   = StIdle;
      done_d    = win_oh;
      err_d     = 1'b1;
      last_d    = win_q;
      rd_data_d = rd_data_q;
      rd_seen_d = rd_seen_q;
    end
`endif
  end

  always_ff @(posedge user_clk or posedge user_rst) begin
    if (user_rst) begin
      state_q   <= StIdle;
      last_q    <= IdxW'(NUM_REQ - 1);
      win_q     <= '0;
      is_rd_q   <= 1'b0;
      wdata_q   <= '0;
      rd_seen_q <= 1'b0;
      ack_q     <= '0;
      done_q    <= '0;
      rd_evt_q  <= 1'b0;
      wr_evt_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      win_q     <= win_d;
      is_rd_q   <= is_rd_d;
      wdata_q   <= wdata_d;
      rd_seen_q <= rd_seen_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      rd_evt_q  <= rd_evt_d;
      wr_evt_q  <= wr_evt_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign o_ack         = ack_q;
  assign o_done        = done_q;
  assign o_rd_data     = rd_data_q;
  assign o_busy        = (state_q != StIdle);
  assign o_spi_rd_evt  = rd_evt_q;
  assign o_spi_wr_evt  = wr_evt_q;
  assign o_spi_wr_data = o_busy ? wdata_q : '0;

endmodule

// File: tb/tb_spi_arbiter.sv
module tb_spi_arbiter;

  localparam int NR = 4;
  localparam int DW = 16;

  logic              user_clk = 1'b0;
  logic              user_rst;
  logic [NR-1:0]     i_req;
  logic [NR-1:0]     i_req_rd;
  logic [NR*DW-1:0]  i_req_wdata;
  logic [NR-1:0]     o_ack;
  logic [NR-1:0]     o_done;
  logic [DW-1:0]     o_rd_data;
  logic              o_err;
  logic              o_busy;
  logic              o_spi_rd_evt;
  logic              o_spi_wr_evt;
  logic [DW-1:0]     o_spi_wr_data;
  logic              i_spi_rd_evt;
  logic [DW-1:0]     i_spi_rd_data;
  logic              i_mcs;

  int n_assert = 0;
  int n_fail   = 0;

  spi_arbiter #(
    .NUM_REQ         (NR),
    .DATA_WIDTH      (DW),
    .MCS_VALID_LEVEL (1'b0),
    .TIMEOUT_CYCLES  (64)
  ) dut (
    .user_clk      (user_clk),
    .user_rst      (user_rst),
    .i_req         (i_req),
    .i_req_rd      (i_req_rd),
    .i_req_wdata   (i_req_wdata),
    .o_ack         (o_ack),
    .o_done        (o_done),
    .o_rd_data     (o_rd_data),
    .o_err         (o_err),
    .o_busy        (o_busy),
    .o_spi_rd_evt  (o_spi_rd_evt),
    .o_spi_wr_evt  (o_spi_wr_evt),
    .o_spi_wr_data (o_spi_wr_data),
    .i_spi_rd_evt  (i_spi_rd_evt),
    .i_spi_rd_data (i_spi_rd_data),
    .i_mcs         (i_mcs)
  );

  always #5 user_clk = ~user_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge user_clk);
    #1;
  endtask

  // One full transaction from an idle arbiter whose request is already raised.
  task automatic do_txn(input string tag, input logic [3:0] exp_ack, input bit is_rd,
                        input logic [15:0] val);
    tick();
    chk({tag, ".ack"}, 32'(o_ack), 32'(exp_ack));
    chk({tag, ".busy"}, 32'(o_busy), 32'd1);
    i_req = i_req & ~exp_ack;
    tick();
    chk({tag, ".rd_evt"}, 32'(o_spi_rd_evt), 32'(is_rd));
    chk({tag, ".wr_evt"}, 32'(o_spi_wr_evt), 32'(!is_rd));
    chk({tag, ".ack_pulse"}, 32'(o_ack), 32'd0);
    if (!is_rd) chk({tag, ".wr_data"}, 32'(o_spi_wr_data), 32'(val));
    i_mcs = 1'b0;
    tick();
    chk({tag, ".evt_once"}, 32'({o_spi_rd_evt, o_spi_wr_evt}), 32'd0);
    if (is_rd) begin
      i_spi_rd_evt  = 1'b1;
      i_spi_rd_data = val;
      tick();
      i_spi_rd_evt  = 1'b0;
      i_spi_rd_data = 16'hFFFF;
    end
    i_mcs = 1'b1;
    tick();
    chk({tag, ".done_early"}, 32'(o_done), 32'd0);
    tick();
    chk({tag, ".done"}, 32'(o_done), 32'(exp_ack));
    chk({tag, ".err"}, 32'(o_err), 32'd0);
    chk({tag, ".idle"}, 32'(o_busy), 32'd0);
    if (is_rd) chk({tag, ".rd_data"}, 32'(o_rd_data), 32'(val));
    tick();
    chk({tag, ".done_pulse"}, 32'(o_done), 32'd0);
    chk({tag, ".gap"}, 32'(o_ack), 32'd0);
  endtask

  initial begin
    int early;
    user_rst      = 1'b1;
    i_req         = '0;
    i_req_rd      = '0;
    i_req_wdata   = {16'h3333, 16'h2222, 16'h1111, 16'hA5C3};
    i_spi_rd_evt  = 1'b0;
    i_spi_rd_data = '0;
    i_mcs         = 1'b1;
    tick();
    tick();
    chk("rst.ack", 32'(o_ack), 32'd0);
    chk("rst.done", 32'(o_done), 32'd0);
    chk("rst.busy", 32'(o_busy), 32'd0);
    chk("rst.evt", 32'({o_spi_rd_evt, o_spi_wr_evt}), 32'd0);
    chk("rst.wr_data", 32'(o_spi_wr_data), 32'd0);
    chk("rst.rd_data", 32'(o_rd_data), 32'd0);
    chk("rst.err", 32'(o_err), 32'd0);
    user_rst = 1'b0;
    tick();

    // Single write from requester 0.
    i_req = 4'b0001;
    do_txn("wr0", 4'b0001, 1'b0, 16'hA5C3);

    // Single read from requester 2.
    i_req    = 4'b0100;
    i_req_rd = 4'b0100;
    do_txn("rd2", 4'b0100, 1'b1, 16'h1234);

    // Read whose data arrives after chip select releases (requester 1).
    i_req    = 4'b0010;
    i_req_rd = 4'b0010;
    tick();
    chk("late.ack", 32'(o_ack), 32'b0010);
    i_req = '0;
    tick();
    chk("late.rd_evt", 32'(o_spi_rd_evt), 32'd1);
    i_mcs = 1'b0;
    tick();
    i_mcs = 1'b1;
    tick();
    tick();
    chk("late.wait_done", 32'(o_done), 32'd0);
    chk("late.wait_busy", 32'(o_busy), 32'd1);
    i_spi_rd_evt  = 1'b1;
    i_spi_rd_data = 16'hBEEF;
    tick();
    i_spi_rd_evt  = 1'b0;
    i_spi_rd_data = 16'hFFFF;
    chk("late.rd_data", 32'(o_rd_data), 32'hBEEF);
    chk("late.done_early", 32'(o_done), 32'd0);
    tick();
    chk("late.done", 32'(o_done), 32'b0010);
    tick();

    // Read-data pulse while idle must be ignored.
    i_spi_rd_evt  = 1'b1;
    i_spi_rd_data = 16'hDEAD;
    tick();
    i_spi_rd_evt  = 1'b0;
    tick();
    chk("ign.rd_data", 32'(o_rd_data), 32'hBEEF);
    chk("ign.busy", 32'(o_busy), 32'd0);

    // Reset during WAIT_END of a write from requester 3.
    i_req    = 4'b1000;
    i_req_rd = 4'b0000;
    tick();
    chk("mid.ack", 32'(o_ack), 32'b1000);
    i_req = '0;
    tick();
    chk("mid.wr_evt", 32'(o_spi_wr_evt), 32'd1);
    chk("mid.wr_data", 32'(o_spi_wr_data), 32'h3333);
    i_mcs = 1'b0;
    tick();
    tick();
    user_rst = 1'b1;
    #1;
    chk("mid.rst_busy", 32'(o_busy), 32'd0);
    chk("mid.rst_outs", 32'({o_ack, o_done, o_spi_rd_evt, o_spi_wr_evt, o_err}), 32'd0);
    chk("mid.rst_wr_data", 32'(o_spi_wr_data), 32'd0);
    chk("mid.rst_rd_data", 32'(o_rd_data), 32'd0);
    tick();
    user_rst = 1'b0;
    i_mcs    = 1'b1;
    tick();
    chk("mid.no_done1", 32'(o_done), 32'd0);
    tick();
    chk("mid.no_done2", 32'(o_done), 32'd0);

    // All four requesting: grant order 0,1,2,3,0.
    i_req = 4'b1111;
    do_txn("rr0", 4'b0001, 1'b0, 16'hA5C3);
    do_txn("rr1", 4'b0010, 1'b0, 16'h1111);
    i_req[0] = 1'b1;
    do_txn("rr2", 4'b0100, 1'b0, 16'h2222);
    do_txn("rr3", 4'b1000, 1'b0, 16'h3333);
    do_txn("rr4", 4'b0001, 1'b0, 16'hA5C3);
    chk("rr.all_served", 32'(i_req), 32'd0);

`ifdef SPI_ARB_TIMEOUT_EN
    // Chip select never asserts: abort 64 cycles after WAIT_START entry.
    i_req = 4'b0001;
    tick();
    chk("to.ack", 32'(o_ack), 32'b0001);
    i_req = '0;
    tick();
    chk("to.wr_evt", 32'(o_spi_wr_evt), 32'd1);
    early = 0;
    for (int i = 1; i < 64; i++) begin
      tick();
      if (o_err !== 1'b0 || o_done !== 4'b0000) early++;
    end
    chk("to.early", 32'(early), 32'd0);
    tick();
    chk("to.err", 32'(o_err), 32'd1);
    chk("to.done", 32'(o_done), 32'b0001);
    chk("to.idle", 32'(o_busy), 32'd0);
    chk("to.rd_data", 32'(o_rd_data), 32'd0);
    tick();
    chk("to.err_pulse", 32'(o_err), 32'd0);
`else
    early = 0;
    chk("no_to.err", 32'(o_err | 1'(early)), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 16, SPI word width.
REQ-003 SHALL have parameter MCS_VALID_LEVEL, default 1'b0, active level of the monitored chip select.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 4096, user_clk cycles allowed per transaction phase.
REQ-005 SHALL have port user_clk  input  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port user_rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port i_req  input  NUM_REQ  per-requester request level, held until the matching o_ack.
REQ-008 SHALL have port i_req_rd  input  NUM_REQ  per-requester type: 1 = read, 0 = write.
REQ-009 SHALL have port i_req_wdata  input  NUM_REQ*DATA_WIDTH  per-requester write payload; requester k uses slice [k*DATA_WIDTH +: DATA_WIDTH].
REQ-010 SHALL have port o_ack  output  NUM_REQ  one-cycle pulse; request accepted.
REQ-011 SHALL have port o_done  output  NUM_REQ  one-cycle pulse; transaction complete.
REQ-012 SHALL have port o_rd_data  output  DATA_WIDTH  read result, valid with o_done of a read.
REQ-013 SHALL have port o_err  output  1  one-cycle pulse; timeout abort.
REQ-014 SHALL have port o_busy  output  1  high whenever the FSM is not IDLE.
REQ-015 SHALL have port o_spi_rd_evt  output  1  read-event pulse to the SPI master.
REQ-016 SHALL have port o_spi_wr_evt  output  1  write-event pulse to the SPI master.
REQ-017 SHALL have port o_spi_wr_data  output  DATA_WIDTH  write payload to the SPI master.
REQ-018 SHALL have port i_spi_rd_evt  input  1  read-data-valid pulse from the SPI master.
REQ-019 SHALL have port i_spi_rd_data  input  DATA_WIDTH  read payload from the SPI master.
REQ-020 SHALL have port i_mcs  input  1  chip select driven by the SPI master.

Function
REQ-021 FSM states SHALL be IDLE, ISSUE, WAIT_START, WAIT_END, DONE.
REQ-022 IDLE: if any i_req is high, SHALL select the winner by round-robin, scanning from (last_grant+1) mod NUM_REQ; capture its index, type and payload; pulse o_ack[winner]; go to ISSUE.
REQ-023 ISSUE: SHALL pulse exactly one of o_spi_rd_evt or o_spi_wr_evt for one cycle, per the captured type; o_spi_wr_data SHALL hold the captured payload from ISSUE until IDLE; go to WAIT_START.
REQ-024 WAIT_START: SHALL go to WAIT_END when i_mcs == MCS_VALID_LEVEL.
REQ-025 WAIT_END: a write SHALL complete when i_mcs != MCS_VALID_LEVEL; a read SHALL complete when i_mcs is inactive and i_spi_rd_evt has been seen since ISSUE, in either order; then go to DONE.
REQ-026 On i_spi_rd_evt during WAIT_START/WAIT_END of a read, SHALL register i_spi_rd_data into o_rd_data; i_spi_rd_evt at any other time SHALL be ignored.
REQ-027 DONE: SHALL pulse o_done[winner] for one cycle; set last_grant = winner; go to IDLE.
REQ-028 Requester-visible latency SHALL be: o_ack 1 cycle after i_req sampled in IDLE; SPI event 1 cycle after o_ack; at least 1 idle cycle between o_done and the next o_ack.
REQ-029 A request deasserted after o_ack SHALL NOT affect the ongoing transaction.
REQ-030 Simultaneous requests SHALL be served one at a time; no requester SHALL wait more than NUM_REQ-1 transactions.

Reset
REQ-031 On user_rst high, the FSM SHALL go to IDLE and last_grant SHALL become NUM_REQ-1, so requester 0 wins first; all outputs SHALL be 0. This applies mid-transaction too, with no o_done issued.

Configuration
REQ-032 With macro SPI_ARB_TIMEOUT_EN defined, a counter SHALL run in WAIT_START and WAIT_END and restart on each state change; on reaching TIMEOUT_CYCLES it SHALL pulse o_err and o_done[winner] together, hold o_rd_data unchanged, advance last_grant, and go to IDLE.
REQ-033 Without SPI_ARB_TIMEOUT_EN, no counter SHALL be built, o_err SHALL be tied 0, and the FSM SHALL wait indefinitely.

Verification
REQ-034 Single write: i_req=4'b0001, i_req_rd=0, wdata0=16'hA5C3 -> o_ack[0], then o_spi_wr_evt with o_spi_wr_data=16'hA5C3, o_done[0] after mcs deasserts.
REQ-035 Single read: i_req[2], rd=1, model returns 16'h1234 -> o_spi_rd_evt once; o_rd_data=16'h1234 at o_done[2].
REQ-036 All four requesters held after reset -> o_ack order 0,1,2,3,0; never two SPI events per transaction.
REQ-037 i_spi_rd_evt arrives after mcs deasserts -> o_done waits for it, with correct data.
REQ-038 user_rst pulsed during WAIT_END -> all outputs 0; next grant goes to requester 0; no stale o_done.
REQ-039 With SPI_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=64, mcs held inactive -> o_err and o_done pulse 64 cycles after WAIT_START entry; FSM returns to IDLE.
